uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
UART receiver for the control SoC's ser_rx line. Complement of the SoC's serial transmitter: 8N1 frames, LSB first, 115200 baud from the 12 MHz board clock. Recovered bytes go into a small FIFO that the SoC bus side drains through a valid/ready port. Sticky error flags are cleared by the bus.

Parameters:
CLK_DIV, 104, clk cycles per bit (12 MHz / 115200, rounded); legal range 8..65535
FIFO_DEPTH, 16, receive FIFO entries; power of 2, 2..256

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ser_rx  input  1  asynchronous serial input, idle high
rd_data  output  8  byte at FIFO head, valid only when rd_valid=1
rd_valid  output  1  FIFO not empty
rd_ready  input  1  pop head when rd_valid=1
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count
frame_err  output  1  sticky; a stop bit was sampled low
overrun  output  1  sticky; a good byte was dropped because the FIFO was full
clr_err  input  1  single-cycle pulse; clears frame_err and overrun (and parity_err if present)

Behaviour:
- Reset values: rd_valid=0, rd_data=0, fifo_level=0, frame_err=0, overrun=0.
  - FSM goes to IDLE; FIFO pointers go to 0.
  - Synchronizer and previous-sample registers reset to 1.
- Input synchronization: ser_rx passes through a 2-FF synchronizer (rx_s).
- Start detection: a start is detected on a 1->0 transition of rx_s while in IDLE.
  - A line that is already low when reset releases never produces a start. A high level must be seen first.
- FSM states and transitions:
  - IDLE: on start detect, load bit counter with CLK_DIV/2 - 1 -> START.
  - START: on counter==0, sample rx_s.
    - If 1: false start (glitch) -> IDLE, nothing recorded.
    - If 0: reload counter to CLK_DIV-1, bit index 0 -> DATA.
  - DATA: on counter==0, shift rx_s into bit[index] (LSB first) and reload counter. After index 7 -> STOP (or PARITY, see Optional Feature).
  - STOP: on counter==0, sample rx_s.
    - If 1: push the byte.
    - If 0: set frame_err and discard the byte.
    - Either way -> IDLE in the same cycle, so a back-to-back start edge in the following half bit is caught.
- Sample timing: samples fall at mid-bit, i.e. CLK_DIV/2 cycles after the detected edge, then every CLK_DIV cycles. The 2-cycle synchronizer delay is uniform and is ignored.
- Push latency: the byte is written at the STOP sample edge. rd_valid/rd_data reflect it on the next cycle (registered FIFO head).
- FIFO:
  - Pop occurs when rd_valid && rd_ready. rd_data shows the new head on the next cycle.
  - Push when full with no pop in the same cycle: the byte is dropped and overrun is set. The FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: the push is accepted and fifo_level stays at FIFO_DEPTH.
  - Push and pop on a non-empty, non-full FIFO: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Errors: an error event in the same cycle as clr_err wins, so the flag is set on the next cycle.
- Reset mid-frame: the partial byte is discarded, the FIFO is emptied, and all flags are cleared next cycle.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1. After DATA the FSM enters PARITY and samples one extra bit mid-bit.
  - If the XOR of the 8 data bits and the parity bit is 1, parity_err (extra output, 1 bit, sticky, reset 0, cleared by clr_err) is set.
  - The byte is discarded after the stop bit regardless of the stop bit's value. frame_err is still evaluated independently.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Test Plan:
- Send 0x55 then 0xA3 at 104 cycles/bit with rd_ready=0 -> fifo_level=2; popping gives 0x55 then 0xA3; rd_valid=0 afterwards; no flags.
- Send 0x3C with stop bit driven low -> frame_err=1, fifo_level=0. Pulse clr_err -> frame_err=0. Next good 0x3C is received normally.
- Send 17 bytes 0x00..0x10 with rd_ready=0 (FIFO_DEPTH=16) -> fifo_level=16, overrun=1; drain yields 0x00..0x0F in order.
- Drive a 20-cycle low glitch on idle ser_rx -> no byte, no flags, FSM back in IDLE. A byte 0x81 sent 200 cycles later is received correctly.
- Assert reset for 1 cycle in the middle of bit 4 of 0xF0, with one byte already queued -> fifo_level=0, no flags. Line returns high, then 0x0F is received correctly.
- Bit period of 101 and 107 cycles (±3%), plus back-to-back frames with zero idle gap -> all bytes 0xDE,0xAD,0xBE,0xEF are received. With UART_RX_PARITY_EN, 0xDE with odd parity -> parity_err=1 and the byte is dropped.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (mid-bit sampling, 2-FF input sync) feeding a valid/ready receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity_err output.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ser_rx,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_err,
    output logic                        overrun,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    input  logic                        clr_err
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic        rx_m, rx_s, rx_prev;
    logic [1:0]  sync_vld;
    logic        armed;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        par_bad;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic        push_req, push_ok, pop, full;

`ifdef UART_RX_PARITY_EN
    assign push_req = (state == STOP) && (cnt == 16'd0) && rx_s && !par_bad;
`else
    assign push_req = (state == STOP) && (cnt == 16'd0) && rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            sync_vld  <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            shreg     <= 8'd0;
            par_bad   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_m     <= ser_rx;
            rx_s     <= rx_m;
            rx_prev  <= rx_s;
            // rx_s only carries the real line once both sync stages have refilled;
            // starts are ignored until a genuine high level has been observed.
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_s) armed <= 1'b1;
            if (clr_err) begin
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            case (state)
                IDLE: if (armed && rx_prev && !rx_s) begin
                    cnt     <= HALF_M1;
                    par_bad <= 1'b0;
                    state   <= START;
                end
                START: if (cnt == 16'd0) begin
                    if (rx_s) state <= IDLE;
                    else begin
                        cnt   <= FULL_M1;
                        idx   <= 3'd0;
                        state <= DATA;
                    end
                end else cnt <= cnt - 16'd1;
                DATA: if (cnt == 16'd0) begin
                    shreg[idx] <= rx_s;
                    cnt        <= FULL_M1;
                    if (idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    else idx <= idx + 3'd1;
                end else cnt <= cnt - 16'd1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == 16'd0) begin
                    par_bad <= ^{shreg, rx_s};
                    if (^{shreg, rx_s}) parity_err <= 1'b1;
                    cnt   <= FULL_M1;
                    state <= STOP;
                end else cnt <= cnt - 16'd1;
`endif
                STOP: if (cnt == 16'd0) begin
                    if (!rx_s) frame_err <= 1'b1;
                    state <= IDLE;
                end else cnt <= cnt - 16'd1;
                default: state <= IDLE;
            endcase
        end
    end

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (clr_err) overrun <= 1'b0;
            if (push_req && full && !pop) overrun <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    assign rd_data    = rd_valid ? mem[rd_ptr] : 8'd0;
    assign fifo_level = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames in, expected bytes queued, FIFO drained and compared.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_rx = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] fifo_level;
    logic       frame_err, overrun;
    logic       clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`else
    logic       parity_err = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_DIV(104), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_level(fifo_level), .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .clr_err(clr_err)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish within 5ms");
        $fatal(1);
    end

    // Sends one frame; rst_bit >= 0 pulses reset in the middle of that data bit and abandons the frame.
    task automatic send_byte(input logic [7:0] b, input int per, input logic stop_v,
                             input logic bad_par, input int rst_bit);
        ser_rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            if (i == rst_bit) begin
                repeat (per / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                ser_rx = 1'b1;
                return;
            end
            repeat (per) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        ser_rx = (^b) ^ bad_par;
        repeat (per) @(negedge clk);
`else
        if (bad_par) ser_rx = 1'b0;
`endif
        ser_rx = stop_v;
        repeat (per) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_level !== 5'd0 ||
            frame_err !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h lvl=%0d fe=%b ov=%b pe=%b want all zero",
                     rd_valid, rd_data, fifo_level, frame_err, overrun, parity_err);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] e;
        send_byte(8'h55, 104, 1'b1, 1'b0, -1); exp_q.push_back(8'h55);
        send_byte(8'hA3, 104, 1'b1, 1'b0, -1); exp_q.push_back(8'hA3);
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 5'(exp_q.size()) || frame_err || overrun || parity_err) begin
            errors++;
            $display("FAIL basic_level lvl=%0d fe=%b ov=%b want lvl=%0d no flags",
                     fifo_level, frame_err, overrun, exp_q.size());
        end
        rd_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL basic_pop got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, e);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty got rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] e;
        send_byte(8'h3C, 104, 1'b0, 1'b0, -1);
        repeat (20) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL frame_err_set got fe=%b lvl=%0d want fe=1 lvl=0", frame_err, fifo_level);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clr got fe=%b want 0", frame_err);
        end
        send_byte(8'h3C, 104, 1'b1, 1'b0, -1); exp_q.push_back(8'h3C);
        repeat (4) @(negedge clk);
        rd_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL frame_good_pop got v=%b d=%h fe=%b want v=1 d=%h fe=0",
                         rd_valid, rd_data, frame_err, e);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] e;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 104, 1'b1, 1'b0, -1);
            if (exp_q.size() < 16) exp_q.push_back(8'(i));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 5'd16 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_full got lvl=%0d ov=%b want lvl=16 ov=1", fifo_level, overrun);
        end
        rd_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL overrun_pop got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, e);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_empty got rd_valid=%b want 0", rd_valid);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr got ov=%b want 0", overrun);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] e;
        ser_rx = 1'b0;
        repeat (20) @(negedge clk);
        ser_rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (fifo_level !== 5'd0 || frame_err || overrun || parity_err) begin
            errors++;
            $display("FAIL glitch_ignored got lvl=%0d fe=%b ov=%b want lvl=0 no flags",
                     fifo_level, frame_err, overrun);
        end
        send_byte(8'h81, 104, 1'b1, 1'b0, -1); exp_q.push_back(8'h81);
        repeat (4) @(negedge clk);
        rd_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL glitch_pop got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, e);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e;
        send_byte(8'h11, 104, 1'b1, 1'b0, -1); exp_q.push_back(8'h11);
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL midrst_pre got lvl=%0d want 1", fifo_level);
        end
        send_byte(8'hF0, 104, 1'b1, 1'b0, 4);
        exp_q.delete();
        checks++;
        if (fifo_level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 ||
            frame_err || overrun || parity_err) begin
            errors++;
            $display("FAIL midrst_clear got lvl=%0d v=%b d=%h fe=%b ov=%b want all zero",
                     fifo_level, rd_valid, rd_data, frame_err, overrun);
        end
        repeat (20) @(negedge clk);
        send_byte(8'h0F, 104, 1'b1, 1'b0, -1); exp_q.push_back(8'h0F);
        repeat (4) @(negedge clk);
        rd_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e || fifo_level !== 5'd1) begin
                errors++;
                $display("FAIL midrst_pop got v=%b d=%h lvl=%0d want v=1 d=%h lvl=1",
                         rd_valid, rd_data, fifo_level, e);
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic [7:0] pat [4];
        pat = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(pat[i], (p == 0) ? 101 : 107, 1'b1, 1'b0, -1);
                exp_q.push_back(pat[i]);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (fifo_level !== 5'd4 || frame_err || overrun || parity_err) begin
                errors++;
                $display("FAIL b2b_level period=%0d got lvl=%0d fe=%b ov=%b want lvl=4 no flags",
                         (p == 0) ? 101 : 107, fifo_level, frame_err, overrun);
            end
            rd_ready = 1'b1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== e) begin
                    errors++;
                    $display("FAIL b2b_pop got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, e);
                end
                @(negedge clk);
            end
            rd_ready = 1'b0;
            repeat (10) @(negedge clk);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_byte(8'hDE, 104, 1'b1, 1'b1, -1);
        repeat (4) @(negedge clk);
        checks++;
        if (parity_err !== 1'b1 || fifo_level !== 5'd0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad got pe=%b lvl=%0d fe=%b want pe=1 lvl=0 fe=0",
                     parity_err, fifo_level, frame_err);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clr got pe=%b want 0", parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
